branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters, serving the IF stage of the pipelined RISC-V CPU. The fetch PC is looked up combinationally each cycle, producing a taken prediction and a predicted target for the PC mux and IF/ID flush logic. The EX stage writes back each resolved conditional branch, training the counter and allocating or refreshing entries.

## Interface
- ENTRIES, 16, number of table entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_pc_i  in  32  fetch PC to look up
- predict_o  out  1  1 = predict taken for if_pc_i
- target_o  out  32  predicted target; 0 when predict_o = 0
- ex_valid_i  in  1  a conditional branch resolves in EX this cycle
- ex_pc_i  in  32  PC of the resolving branch
- ex_taken_i  in  1  actual outcome
- ex_target_i  in  32  actual taken target (PC + imm)
- ex_predicted_i  in  1  prediction carried down the pipe for this branch (present only with BTB_STATS_EN)
- branch_cnt_o  out  32  resolved branch count (present only with BTB_STATS_EN)
- mispredict_cnt_o  out  32  mispredicted branch count (present only with BTB_STATS_EN)

## Operation
- Entry fields: valid (1), tag (30−IDX_W), target (32), ctr (2).
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup: hit = valid & tag match at index(if_pc_i). predict_o = hit & ctr[1]. target_o = predict_o ? entry.target : 0.
- Update (rising edge, ex_valid_i = 1, rst_i = 0):
  - Hit, taken: ctr = min(ctr+1, 3); target = ex_target_i.
  - Hit, not taken: ctr = max(ctr−1, 0); target unchanged.
  - Miss, taken: allocate: valid = 1, tag, target = ex_target_i, ctr = 2'b10. Any previous occupant of the index is overwritten.
  - Miss, not taken: no change.
- ex_valid_i = 0: table holds.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Saturation at 00 and 11 is silent.

## Timing
- Lookup is zero-latency combinational from if_pc_i and the current table.
- Update becomes visible to lookup on the cycle after the write edge.
- Same-cycle lookup and update to the same index: lookup returns pre-update state (no bypass).
- Reset: all valid = 0, ctr = 2'b01, tag/target = 0. predict_o = 0 and target_o = 0 from the first cycle after reset, for every PC.
- rst_i has priority over a coincident update; the update is discarded.
- Reset mid-run drops all learned state. The first branch after reset is always predicted not-taken.

## Configuration
- BTB_STATS_EN defined: ports ex_predicted_i, branch_cnt_o and mispredict_cnt_o exist.
  - On each ex_valid_i edge, branch_cnt_o increments by 1.
  - mispredict_cnt_o increments by 1 when ex_predicted_i ≠ ex_taken_i.
  - Both counters reset to 0 and wrap modulo 2^32.
- BTB_STATS_EN undefined: those three ports and the counters are absent. Prediction behaviour is identical in both builds.

## Test plan
- Reset, then sweep if_pc_i over 0..252 step 4 -> predict_o = 0 and target_o = 0 at every PC.
- ex_valid=1, ex_pc=0x20, taken=1, target=0x08; next cycle if_pc=0x20 -> predict_o = 1, target_o = 0x08 (ctr = 10). Two not-taken updates to 0x20 -> ctr = 00, predict_o = 0. Two more not-taken updates -> ctr stays 00.
- Train 0x20 taken (ENTRIES=16), then taken update at 0x60 (same index, different tag) -> if_pc=0x20 gives predict_o = 0; if_pc=0x60 gives predict_o = 1, target_o = new target.
- if_pc=0x20 and a not-taken update to 0x20 (entry at ctr 10) in the same cycle -> predict_o = 1 that cycle, 0 the next.
- Assert rst_i in the same cycle as a taken update to 0x40 -> if_pc=0x40 gives predict_o = 0 afterwards.
- BTB_STATS_EN build: 5 resolutions with ex_predicted/ex_taken = 1/1, 0/1, 1/0, 0/0, 1/1 -> branch_cnt_o = 5, mispredict_cnt_o = 2.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// Branch target buffer port bundle: IF-stage lookup plus EX-stage branch
// resolution. Optional statistics signals exist only when BTB_STATS_EN is
// defined. The master side is the pipeline and the slave side is the BTB.
interface branch_target_buffer_if;
    // IF-stage lookup
    logic [31:0] if_pc_i;
    logic        predict_o;
    logic [31:0] target_o;

    // EX-stage resolution
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;

`ifdef BTB_STATS_EN
    logic        ex_predicted_i;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;
`endif

`ifdef BTB_STATS_EN
    modport master (
        output if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i, ex_predicted_i,
        input  predict_o, target_o, branch_cnt_o, mispredict_cnt_o
    );
    modport slave (
        input  if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i, ex_predicted_i,
        output predict_o, target_o, branch_cnt_o, mispredict_cnt_o
    );
`else
    modport master (
        output if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
        input  predict_o, target_o
    );
    modport slave (
        input  if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
        output predict_o, target_o
    );
`endif
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// The fetch PC is looked up combinationally; EX-stage resolutions train the
// counter and allocate or refresh entries on the rising edge.
// Optional feature macro: BTB_STATS_EN adds resolved/mispredicted counters.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    branch_target_buffer_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Table storage, one array per field.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    // Lookup side decode.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    // Update side decode and next values for the addressed entry.
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             ent_wr_en;
    logic [1:0]       ent_ctr_d;
    logic [31:0]      ent_target_d;

    // PC byte-offset bits never participate in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc_i[1:0], bus.ex_pc_i[1:0]};

    assign lk_idx = bus.if_pc_i[IDX_W+1:2];
    assign lk_tag = bus.if_pc_i[31:IDX_W+2];
    assign ex_idx = bus.ex_pc_i[IDX_W+1:2];
    assign ex_tag = bus.ex_pc_i[31:IDX_W+2];

    // Lookup: reads the current table only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bus.predict_o = lk_hit && ctr_q[lk_idx][1];
        bus.target_o  = bus.predict_o ? target_q[lk_idx] : 32'h0;
    end

    // Update decision: train on hit, allocate on taken miss, ignore not-taken miss.
    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise paths that skip an assignment infer latches.
        ent_wr_en    = 1'b0;
        ent_ctr_d    = ctr_q[ex_idx];
        ent_target_d = target_q[ex_idx];
        ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        if (bus.ex_valid_i) begin
            if (ex_hit) begin
                ent_wr_en = 1'b1;
                if (bus.ex_taken_i) begin
                    ent_target_d = bus.ex_target_i;
                    if (ctr_q[ex_idx] != CTR_STRONG_T) begin
                        ent_ctr_d = ctr_q[ex_idx] + 2'd1;
                    end
                end else if (ctr_q[ex_idx] != CTR_STRONG_NT) begin
                    ent_ctr_d = ctr_q[ex_idx] - 2'd1;
                end
            end else if (bus.ex_taken_i) begin
                ent_wr_en    = 1'b1;
                ent_ctr_d    = CTR_WEAK_T;
                ent_target_d = bus.ex_target_i;
            end
        end
    end

    // Table state: reset clears every entry, otherwise write the addressed entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the table is reset entry by entry because a post-reset lookup must never hit; this forbids mapping it onto RAM macros.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (ent_wr_en) begin
            // NOTE: non-blocking assignments keep every register update in this edge using pre-edge values.
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ent_target_d;
            ctr_q[ex_idx]    <= ent_ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Statistics next state: count resolutions and direction mispredictions, wrapping.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (bus.ex_valid_i) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (bus.ex_predicted_i != bus.ex_taken_i) begin
                mispredict_cnt_d = mispredict_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= 32'h0;
            mispredict_cnt_q <= 32'h0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES = 16, so
// index = pc[5:2]). Inputs change on the falling edge; combinational outputs
// are sampled 1 time unit later, well away from the rising edge.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    branch_target_buffer_if bus ();

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a fetch PC and check the prediction in the same cycle.
    task automatic look(input logic [31:0] pc, input logic exp_pred,
                        input logic [31:0] exp_tgt, input string tag);
        @(negedge clk);
        bus.if_pc_i = pc;
        #1;
        check({tag, ".predict"}, 32'(bus.predict_o), 32'(exp_pred));
        check({tag, ".target"}, bus.target_o, exp_tgt);
    endtask

    // Drive one EX resolution across one rising edge.
    task automatic resolve(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic pred);
        @(negedge clk);
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = pc;
        bus.ex_taken_i  = taken;
        bus.ex_target_i = tgt;
`ifdef BTB_STATS_EN
        bus.ex_predicted_i = pred;
`else
        if (pred) begin end
`endif
        @(posedge clk);
        #1;
        bus.ex_valid_i = 1'b0;
    endtask

    initial begin
        bus.if_pc_i     = 32'h0;
        bus.ex_valid_i  = 1'b0;
        bus.ex_pc_i     = 32'h0;
        bus.ex_taken_i  = 1'b0;
        bus.ex_target_i = 32'h0;
`ifdef BTB_STATS_EN
        bus.ex_predicted_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: nothing predicted anywhere.
        for (int pc = 0; pc <= 252; pc += 4) begin
            look(32'(pc), 1'b0, 32'h0, $sformatf("reset_sweep_%0d", pc));
        end
`ifdef BTB_STATS_EN
        check("stats.reset_branch", bus.branch_cnt_o, 32'd0);
        check("stats.reset_mispred", bus.mispredict_cnt_o, 32'd0);
`endif

        // Allocate 0x20 taken -> ctr 10.
        resolve(32'h20, 1'b1, 32'h08, 1'b0);
        look(32'h20, 1'b1, 32'h08, "alloc");
        // Not-taken twice: 10 -> 01 -> 00.
        resolve(32'h20, 1'b0, 32'h0, 1'b1);
        look(32'h20, 1'b0, 32'h0, "nt1_ctr01");
        resolve(32'h20, 1'b0, 32'h0, 1'b0);
        look(32'h20, 1'b0, 32'h0, "nt2_ctr00");
        // Two more not-taken must stay at 00: one taken then only reaches 01.
        resolve(32'h20, 1'b0, 32'h0, 1'b0);
        resolve(32'h20, 1'b0, 32'h0, 1'b0);
        look(32'h20, 1'b0, 32'h0, "nt_sat_low");
        resolve(32'h20, 1'b1, 32'h100, 1'b0);
        look(32'h20, 1'b0, 32'h0, "t_from00_ctr01");
        resolve(32'h20, 1'b1, 32'h100, 1'b0);
        look(32'h20, 1'b1, 32'h100, "t_ctr10");
        // Saturate at 11: 10 -> 11 -> 11, then one not-taken leaves 10.
        resolve(32'h20, 1'b1, 32'h100, 1'b1);
        resolve(32'h20, 1'b1, 32'h100, 1'b1);
        resolve(32'h20, 1'b0, 32'h0, 1'b1);
        look(32'h20, 1'b1, 32'h100, "t_sat_high");

        // Same-cycle lookup and not-taken update to 0x20: old state visible.
        @(negedge clk);
        bus.if_pc_i     = 32'h20;
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = 32'h20;
        bus.ex_taken_i  = 1'b0;
        bus.ex_target_i = 32'h0;
`ifdef BTB_STATS_EN
        bus.ex_predicted_i = 1'b1;
`endif
        #1;
        check("no_bypass.predict", 32'(bus.predict_o), 32'd1);
        check("no_bypass.target", bus.target_o, 32'h100);
        @(posedge clk);
        #1 bus.ex_valid_i = 1'b0;
        look(32'h20, 1'b0, 32'h0, "after_nt_ctr01");

        // Alias: 0x20 back to 10, then 0x60 (same index 8) evicts it.
        resolve(32'h20, 1'b1, 32'h104, 1'b0);
        look(32'h20, 1'b1, 32'h104, "retrain_0x20");
        resolve(32'h60, 1'b1, 32'h200, 1'b0);
        look(32'h20, 1'b0, 32'h0, "evicted_0x20");
        look(32'h60, 1'b1, 32'h200, "alloc_0x60");
        look(32'h63, 1'b1, 32'h200, "pc_low_bits_ignored");
        // Not-taken miss at 0xA0 (index 8) leaves the entry alone.
        resolve(32'hA0, 1'b0, 32'h300, 1'b0);
        look(32'h60, 1'b1, 32'h200, "nt_miss_no_change");
        look(32'hA0, 1'b0, 32'h0, "nt_miss_no_alloc");
        // Inputs wiggling with ex_valid low do not touch the table.
        @(negedge clk);
        bus.ex_pc_i    = 32'h60;
        bus.ex_taken_i = 1'b0;
        repeat (2) @(posedge clk);
        look(32'h60, 1'b1, 32'h200, "valid_low_hold");

        // Reset with a coincident taken update to 0x40: update discarded.
        @(negedge clk);
        rst             = 1'b1;
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = 32'h40;
        bus.ex_taken_i  = 1'b1;
        bus.ex_target_i = 32'h300;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.ex_valid_i = 1'b0;
        look(32'h40, 1'b0, 32'h0, "rst_priority_0x40");
        look(32'h60, 1'b0, 32'h0, "rst_drops_0x60");
`ifdef BTB_STATS_EN
        check("stats.midrun_reset_branch", bus.branch_cnt_o, 32'd0);
        check("stats.midrun_reset_mispred", bus.mispredict_cnt_o, 32'd0);
        // predicted/taken: 1/1, 0/1, 1/0, 0/0, 1/1 -> 5 branches, 2 mispredicts.
        resolve(32'h80, 1'b1, 32'h10, 1'b1);
        resolve(32'h80, 1'b1, 32'h10, 1'b0);
        resolve(32'h80, 1'b0, 32'h0, 1'b1);
        resolve(32'h80, 1'b0, 32'h0, 1'b0);
        resolve(32'h80, 1'b1, 32'h10, 1'b1);
        check("stats.branch_cnt", bus.branch_cnt_o, 32'd5);
        check("stats.mispredict_cnt", bus.mispredict_cnt_o, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
